// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_types (package)
// Purpose  : Shared types and constants for the rv32i instruction-fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Power-of-two FIFO of fetched {pc, inst} entries with flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
    import rv32i_types::*;
#(
    parameter int FQ_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq,
    input  fetch_entry_t               enq_data,
    input  logic                       deq,
    output fetch_entry_t               head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(FQ_DEPTH):0]  count
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FQ_DEPTH);

    fetch_entry_t  mem_q [FQ_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_enq;
    logic          do_deq;

    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_CNT);
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];
    assign do_deq = deq && !empty;
    // A pop in the same cycle frees the slot, so a full queue may still accept.
    assign do_enq = enq && (!full || do_deq);

    always_ff @(posedge clk) begin
        if (do_enq && !flush) begin
            mem_q[wr_ptr_q] <= enq_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_deq) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : rv32i fetch front end: PC sequencing, one-outstanding imem
//            requests, fetch queue, redirect flush and program ordering.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 4,
    parameter int          ORDER_W  = 64
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        imem_addr,
    output logic [3:0]         imem_rmask,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_resp,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_inst,
    output logic [ORDER_W-1:0] out_order
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FQ_DEPTH);

    fetch_state_t       state_q;
    logic [31:0]        pc_q;
    logic [31:0]        req_pc_q;
    logic [ORDER_W-1:0] order_q;

    fetch_entry_t       q_head;
    fetch_entry_t       q_enq_data;
    logic               q_empty;
    logic               q_full;
    logic [CW-1:0]      q_count;
    logic               issue;
    logic               enq;
    logic               deq;

    // Credit: with at most one request in flight, count < depth guarantees room.
    assign issue      = !rst && (state_q == IDLE) && !redirect_valid && (q_count < DEPTH_CNT);
    assign imem_addr  = pc_q;
    assign imem_rmask = issue ? 4'hF : 4'h0;

    assign enq        = (state_q == WAIT) && imem_resp && !redirect_valid;
    assign q_enq_data = '{pc: req_pc_q, inst: imem_rdata};

    assign out_valid  = !q_empty && !redirect_valid;
    assign deq        = out_valid && out_ready;
    assign out_pc     = q_empty ? 32'h0 : q_head.pc;
    assign out_inst   = q_empty ? 32'h0 : q_head.inst;
    assign out_order  = order_q;

    fetch_queue #(
        .FQ_DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .enq      (enq),
        .enq_data (q_enq_data),
        .deq      (deq),
        .head     (q_head),
        .empty    (q_empty),
        .full     (q_full),
        .count    (q_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            order_q  <= '0;
        end else begin
            if (deq) begin
                order_q <= order_q + ORDER_W'(1);
            end
            if (redirect_valid) begin
                pc_q <= redirect_pc & ~32'd3;
                // A response landing in the redirect cycle is simply dropped.
                if (state_q == WAIT) begin
                    state_q <= imem_resp ? IDLE : DISCARD;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (issue) begin
                            req_pc_q <= pc_q;
                            pc_q     <= pc_q + 32'd4;
                            state_q  <= WAIT;
                        end
                    end
                    WAIT, DISCARD: begin
                        if (imem_resp) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq && q_full));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Directed self-checking bench for if_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [63:0] out_order;

    if_fetch_unit #(
        .RESET_PC (RPC),
        .FQ_DEPTH (4),
        .ORDER_W  (64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rmask     (imem_rmask),
        .imem_rdata     (imem_rdata),
        .imem_resp      (imem_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_order      (out_order)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [63:0] order;
        int          cyc;
    } acc_t;

    acc_t        acc[$];
    logic [31:0] req_log[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    bit          mem_en;
    int          mem_lat;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic [3:0]  s_rmask;
    logic [31:0] s_addr, s_pc, s_inst;
    logic        s_ov;
    logic [63:0] s_ord;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    // Sample the current cycle at negedge, then advance and let the memory model answer.
    task automatic tick();
        @(negedge clk);
        s_rmask = imem_rmask; s_addr = imem_addr; s_ov = out_valid;
        s_pc = out_pc; s_inst = out_inst; s_ord = out_order;
        if (imem_rmask == 4'hF) begin
            req_log.push_back(imem_addr);
            if (mem_en) begin mem_cnt = mem_lat; mem_addr = imem_addr; end
        end
        if (out_valid && out_ready) acc.push_back('{out_pc, out_inst, out_order, cyc});
        cyc++;
        @(posedge clk); #1;
        if (mem_en) begin
            imem_resp = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin imem_resp = 1'b1; imem_rdata = inst_of(mem_addr); end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        imem_resp = 1'b0; imem_rdata = 32'h0; mem_en = 1'b1; mem_lat = 1; mem_cnt = 0;
        tick(); tick();
        rst = 1'b0; cyc = 0; acc.delete(); req_log.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (s_rmask !== 4'h0) $display("FAIL reset_rmask: got %h want 0", s_rmask); else n_pass++;
        n_total++; if (s_addr !== RPC) $display("FAIL reset_addr: got %h want %h", s_addr, RPC); else n_pass++;
        n_total++; if (s_ov !== 1'b0) $display("FAIL reset_valid: got %b want 0", s_ov); else n_pass++;
        n_total++; if (s_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", s_pc); else n_pass++;
        n_total++; if (s_inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", s_inst); else n_pass++;
        n_total++; if (s_ord !== 64'h0) $display("FAIL reset_order: got %0d want 0", s_ord); else n_pass++;
    endtask

    task automatic test_sequential();
        do_reset(); mem_lat = 1; out_ready = 1'b1;
        repeat (7) tick();
        n_total++; if (req_log.size() < 3) $display("FAIL seq_req_count: got %0d want >=3", req_log.size()); else n_pass++;
        n_total++; if (acc.size() != 3) $display("FAIL seq_acc_count: got %0d want 3", acc.size()); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] e;
            e = RPC + 32'(i * 4);
            if (i < req_log.size()) begin
                n_total++; if (req_log[i] !== e) $display("FAIL seq_req[%0d]: got %h want %h", i, req_log[i], e); else n_pass++;
            end
            if (i < acc.size()) begin
                n_total++; if (acc[i].pc !== e) $display("FAIL seq_pc[%0d]: got %h want %h", i, acc[i].pc, e); else n_pass++;
                n_total++; if (acc[i].inst !== inst_of(e)) $display("FAIL seq_inst[%0d]: got %h want %h", i, acc[i].inst, inst_of(e)); else n_pass++;
                n_total++; if (acc[i].order !== 64'(i)) $display("FAIL seq_order[%0d]: got %0d want %0d", i, acc[i].order, i); else n_pass++;
                n_total++; if (acc[i].cyc != 2 + 2 * i) $display("FAIL seq_cycle[%0d]: got %0d want %0d", i, acc[i].cyc, 2 + 2 * i); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(); mem_lat = 1; out_ready = 1'b0;
        repeat (14) tick();
        n_total++; if (req_log.size() != 4) $display("FAIL bp_req_count: got %0d want 4", req_log.size()); else n_pass++;
        n_total++; if (s_rmask !== 4'h0) $display("FAIL bp_rmask_idle: got %h want 0", s_rmask); else n_pass++;
        n_total++; if (s_ov !== 1'b1 || s_ord !== 64'h0) $display("FAIL bp_head: got valid %b order %0d want 1/0", s_ov, s_ord); else n_pass++;
        out_ready = 1'b1;
        repeat (12) tick();
        n_total++; if (acc.size() < 5) $display("FAIL bp_acc_count: got %0d want >=5", acc.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            logic [31:0] e;
            e = RPC + 32'(i * 4);
            if (i < acc.size()) begin
                n_total++; if (acc[i].pc !== e || acc[i].order !== 64'(i))
                    $display("FAIL bp_drain[%0d]: got %h/%0d want %h/%0d", i, acc[i].pc, acc[i].order, e, i); else n_pass++;
                if (i < 4) begin
                    n_total++; if (acc[i].cyc != acc[0].cyc + i) $display("FAIL bp_drain_cycle[%0d]: got %0d want %0d", i, acc[i].cyc, acc[0].cyc + i); else n_pass++;
                end
            end
        end
        n_total++; if (req_log.size() < 5 || req_log[4] !== RPC + 32'h10)
            $display("FAIL bp_resume: got %0d requests want 5th at %h", req_log.size(), RPC + 32'h10); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        do_reset(); mem_lat = 3; out_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h1eceb100;
        tick();
        redirect_valid = 1'b0;
        repeat (10) tick();
        n_total++; if (req_log.size() != 4 || req_log[2] !== 32'h1eceb100)
            $display("FAIL rw_req: got %0d requests, third %h want 4 / 1eceb100", req_log.size(), req_log[2]); else n_pass++;
        n_total++; if (acc.size() != 2) $display("FAIL rw_acc_count: got %0d want 2", acc.size()); else n_pass++;
        if (acc.size() == 2) begin
            n_total++; if (acc[0].pc !== RPC || acc[0].order !== 64'd0) $display("FAIL rw_first: got %h/%0d want %h/0", acc[0].pc, acc[0].order, RPC); else n_pass++;
            n_total++; if (acc[1].pc !== 32'h1eceb100) $display("FAIL rw_pc: got %h want 1eceb100", acc[1].pc); else n_pass++;
            n_total++; if (acc[1].inst !== inst_of(32'h1eceb100)) $display("FAIL rw_inst: got %h want %h", acc[1].inst, inst_of(32'h1eceb100)); else n_pass++;
            n_total++; if (acc[1].order !== 64'd1) $display("FAIL rw_order: got %0d want 1", acc[1].order); else n_pass++;
        end
    endtask

    task automatic test_redirect_resp();
        do_reset(); mem_lat = 1; out_ready = 1'b0;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h1eceb200; out_ready = 1'b1;
        tick();
        n_total++; if (s_ov !== 1'b0) $display("FAIL rr_valid_gate: got %b want 0", s_ov); else n_pass++;
        n_total++; if (s_ord !== 64'd0) $display("FAIL rr_order: got %0d want 0", s_ord); else n_pass++;
        redirect_valid = 1'b0;
        tick();
        n_total++; if (s_ov !== 1'b0) $display("FAIL rr_no_enq: got %b want 0", s_ov); else n_pass++;
        n_total++; if (s_rmask !== 4'hF || s_addr !== 32'h1eceb200) $display("FAIL rr_req: got %h@%h want f@1eceb200", s_rmask, s_addr); else n_pass++;
        repeat (3) tick();
        n_total++; if (acc.size() != 1 || acc[0].pc !== 32'h1eceb200 || acc[0].order !== 64'd0)
            $display("FAIL rr_acc: got %0d accepted, first %h/%0d want 1, 1eceb200/0", acc.size(), acc[0].pc, acc[0].order); else n_pass++;
    endtask

    task automatic test_redirect_wrap();
        do_reset(); mem_lat = 1; out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFE;
        tick();
        n_total++; if (s_rmask !== 4'h0) $display("FAIL wrap_no_issue: got %h want 0", s_rmask); else n_pass++;
        redirect_valid = 1'b0;
        repeat (6) tick();
        n_total++; if (req_log.size() < 2 || req_log[0] !== 32'hFFFFFFFC || req_log[1] !== 32'h0)
            $display("FAIL wrap_req: got %h,%h want fffffffc,00000000", req_log[0], req_log[1]); else n_pass++;
        n_total++; if (acc.size() < 2 || acc[0].pc !== 32'hFFFFFFFC || acc[0].inst !== inst_of(32'hFFFFFFFC) || acc[1].pc !== 32'h0 || acc[1].order !== 64'd1)
            $display("FAIL wrap_acc: got %h/%h/%0d want fffffffc/00000000/1", acc[0].pc, acc[1].pc, acc[1].order); else n_pass++;
    endtask

    task automatic test_reset_midflight();
        do_reset(); mem_lat = 1; out_ready = 1'b1;
        repeat (3) tick();
        mem_en = 1'b0; mem_cnt = 0; imem_resp = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; imem_resp = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        n_total++; if (s_rmask !== 4'hF || s_addr !== RPC) $display("FAIL rm_req: got %h@%h want f@%h", s_rmask, s_addr, RPC); else n_pass++;
        imem_rdata = inst_of(RPC);
        tick();
        n_total++; if (s_ov !== 1'b0) $display("FAIL rm_stale_dropped: got %b want 0", s_ov); else n_pass++;
        imem_resp = 1'b0;
        tick();
        n_total++; if (s_ov !== 1'b1 || s_pc !== RPC) $display("FAIL rm_head: got %b/%h want 1/%h", s_ov, s_pc, RPC); else n_pass++;
        n_total++; if (s_inst !== inst_of(RPC)) $display("FAIL rm_inst: got %h want %h", s_inst, inst_of(RPC)); else n_pass++;
        n_total++; if (s_ord !== 64'd0) $display("FAIL rm_order: got %0d want 0", s_ord); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_resp();
        test_redirect_wrap();
        test_reset_midflight();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
